alarm_fsm: RTL and testbench
============================

ALARM_FSM -- requirements
Module: alarm_fsm

Interface
REQ-001 Parameter CODE, default 16'h1234, four BCD digits of arm/disarm code, most significant digit entered first.
REQ-002 Parameter EXIT_CYCLES, default 20, exit-delay length in clock cycles.
REQ-003 Parameter ENTRY_CYCLES, default 10, entry-delay length in clock cycles.
REQ-004 Parameter ALARM_CYCLES, default 50, alarm duration in clock cycles before automatic re-arm.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 key_valid  input  1  one-cycle strobe qualifying key_digit.
REQ-008 key_digit  input  4  keypad value; 0-9 digit, 4'hF clears entry buffer, 4'hA-4'hE ignored.
REQ-009 sensor  input  4  asynchronous level sensors, 1 = tripped; bit 0 delayed (door) zone, bits 3:1 instant zones.
REQ-010 state  output  2  system state to indicator/siren block: 2'b00 UNARMED, 2'b01 ARMED, 2'b10 ALARM; 2'b11 never driven.
REQ-011 delay  output  1  high while an exit or entry delay runs (beeper).
REQ-012 code_ok  output  1  one-cycle pulse, correct 4-digit code accepted.
REQ-013 code_err  output  1  one-cycle pulse, wrong 4-digit code entered.

Function
REQ-014 Each sensor bit shall pass a 2-flop synchronizer; FSM uses synchronized values only.
REQ-015 Internal states: IDLE, EXIT, ARMED, ENTRY, ALARM; state output maps IDLE->00, EXIT/ARMED/ENTRY->01, ALARM->10.
REQ-016 Accepted digits shall shift into a 4-digit buffer with 0-4 digit count; 4'hF clears buffer and count, no pulse.
REQ-017 On the edge accepting the 4th digit, buffer shall be compared with CODE, cleared, and code_ok or code_err pulsed in the following cycle.
REQ-018 Match in IDLE: IDLE->EXIT, exit counter loaded.
REQ-019 Match in EXIT, ARMED, ENTRY or ALARM: ->IDLE, all counters and error count cleared.
REQ-020 EXIT shall last exactly EXIT_CYCLES cycles, then ->ARMED; sensors ignored during EXIT.
REQ-021 ARMED: synchronized sensor[3:1] nonzero ->ALARM; sensor[0] alone ->ENTRY, entry counter loaded.
REQ-022 ENTRY shall last exactly ENTRY_CYCLES cycles without match, then ->ALARM; instant-zone trip during ENTRY ->ALARM immediately.
REQ-023 ALARM shall last exactly ALARM_CYCLES cycles without match, then ->ARMED; an active sensor then re-triggers per REQ-021.
REQ-024 delay shall be 1 exactly in EXIT and ENTRY.
REQ-025 Consecutive code_err count (0-3) shall clear on code_ok or entry to IDLE; 3rd error in ARMED or ENTRY ->ALARM; in IDLE/EXIT counts but causes no transition, saturates at 3.
REQ-026 Priority same cycle: code match > error-count trip > instant sensor > delay/alarm timeout > delayed sensor.
REQ-027 key_valid with ignored digit 4'hA-4'hE shall change nothing.
REQ-028 Counters shall be wide enough for their parameter; no wrap-around within a state.
REQ-029 state, delay, code_ok, code_err shall be registered outputs.

Reset
REQ-030 rst high at a clock edge shall force IDLE (state=00), delay=0, code_ok=0, code_err=0, and clear buffer, digit count, error count, counters, synchronizers.
REQ-031 rst shall override every other input, including mid-delay, mid-alarm and mid-code-entry.

Verification
REQ-032 Reset, key 1,2,3,4 on consecutive cycles -> code_ok pulse, state=01, delay=1 for 20 cycles, then delay=0, state=01.
REQ-033 ARMED, sensor[2]=1 -> state=10 within 3 cycles, held 50 cycles, then 01; sensor still high -> back to 10 next cycles.
REQ-034 ARMED, sensor[0] pulse -> delay=1 for 10 cycles then state=10; repeat with 1,2,3,4 during ENTRY -> state=00, no alarm.
REQ-035 ARMED, enter 9,9,9,9 three times -> three code_err pulses, state=10 after third; 1,2,3,F,1,2,3,4 -> single code_ok only after second group.
REQ-036 Sensor trip and 4th correct digit same edge in ARMED -> state=00; rst asserted during ALARM -> state=00, delay=0 next cycle.

Source files
------------

// File: rtl/alarm_fsm_if.sv
// Keypad, sensor and indicator signals shared between the alarm controller
// and its surroundings (keypad scanner, sensor wiring, siren/indicator block).
interface alarm_fsm_if;
  logic       key_valid;
  logic [3:0] key_digit;
  logic [3:0] sensor;
  logic [1:0] state;
  logic       delay;
  logic       code_ok;
  logic       code_err;

  modport master (
    output key_valid, key_digit, sensor,
    input  state, delay, code_ok, code_err
  );

  modport slave (
    input  key_valid, key_digit, sensor,
    output state, delay, code_ok, code_err
  );
endinterface

// File: rtl/alarm_fsm.sv
// Keypad-armed intruder alarm: 4-digit code entry, exit/entry delays,
// instant and delayed sensor zones, timed alarm with automatic re-arm.
module alarm_fsm #(
  parameter logic [15:0] CODE         = 16'h1234,
  parameter int          EXIT_CYCLES  = 20,
  parameter int          ENTRY_CYCLES = 10,
  parameter int          ALARM_CYCLES = 50
) (
  input  logic       clk,
  input  logic       rst,
  alarm_fsm_if.slave bus
);

  localparam int MAX_A   = (EXIT_CYCLES > ENTRY_CYCLES) ? EXIT_CYCLES : ENTRY_CYCLES;
  localparam int MAX_CYC = (MAX_A > ALARM_CYCLES) ? MAX_A : ALARM_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC + 1) : 1;

  // Counters load length-1 and leave their state when they reach zero.
  localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALARM_LOAD = CNT_W'(ALARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXIT,
    S_ARMED,
    S_ENTRY,
    S_ALARM
  } state_t;

  function automatic logic [1:0] enc_state(input state_t s);
    case (s)
      S_EXIT, S_ARMED, S_ENTRY: enc_state = 2'b01;
      S_ALARM:                  enc_state = 2'b10;
      default:                  enc_state = 2'b00;
    endcase
  endfunction

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       r_sync_p0;
  logic [3:0]       r_sync_p1;
  logic [11:0]      r_buf;
  logic [1:0]       r_dcnt;
  logic [1:0]       r_err;
  logic [1:0]       w_err_nxt;
  logic [1:0]       r_state_o;
  logic             r_delay;
  logic             r_ok;
  logic             r_err_pulse;

  logic w_digit, w_clear, w_fourth, w_match, w_wrong, w_err_trip;
  logic w_instant, w_door;

  // Stage p0/p1: two-flop synchronizer for the asynchronous sensor levels
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_p0 <= 4'd0;
      r_sync_p1 <= 4'd0;
    end else begin
      r_sync_p0 <= bus.sensor;
      r_sync_p1 <= r_sync_p0;
    end
  end

  assign w_instant = |r_sync_p1[3:1];
  assign w_door    = r_sync_p1[0];

  // Only three digits are ever stored: the fourth is compared on arrival.
  assign w_digit  = bus.key_valid && (bus.key_digit <= 4'd9);
  assign w_clear  = bus.key_valid && (bus.key_digit == 4'hF);
  assign w_fourth = w_digit && (r_dcnt == 2'd3);
  assign w_match  = w_fourth && ({r_buf, bus.key_digit} == CODE);
  assign w_wrong  = w_fourth && !w_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf  <= 12'd0;
      r_dcnt <= 2'd0;
    end else if (w_clear || w_fourth) begin
      r_buf  <= 12'd0;
      r_dcnt <= 2'd0;
    end else if (w_digit) begin
      r_buf  <= {r_buf[7:0], bus.key_digit};
      r_dcnt <= r_dcnt + 2'd1;
    end
  end

  always_comb begin
    w_err_nxt = r_err;
    if (w_match)
      w_err_nxt = 2'd0;
    else if (w_wrong && (r_err != 2'd3))
      w_err_nxt = r_err + 2'd1;
  end

  assign w_err_trip = w_wrong && (w_err_nxt == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) r_err <= 2'd0;
    else     r_err <= w_err_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Branch order inside each state encodes the same-cycle priority.
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_match) begin
          w_next    = S_EXIT;
          w_cnt_nxt = EXIT_LOAD;
        end
      end
      S_EXIT: begin
        if (w_match) begin
          w_next    = S_IDLE;
          w_cnt_nxt = '0;
        end else if (r_cnt == '0) begin
          w_next = S_ARMED;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      S_ARMED: begin
        if (w_match) begin
          w_next    = S_IDLE;
          w_cnt_nxt = '0;
        end else if (w_err_trip || w_instant) begin
          w_next    = S_ALARM;
          w_cnt_nxt = ALARM_LOAD;
        end else if (w_door) begin
          w_next    = S_ENTRY;
          w_cnt_nxt = ENTRY_LOAD;
        end
      end
      S_ENTRY: begin
        if (w_match) begin
          w_next    = S_IDLE;
          w_cnt_nxt = '0;
        end else if (w_err_trip || w_instant || (r_cnt == '0)) begin
          w_next    = S_ALARM;
          w_cnt_nxt = ALARM_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      S_ALARM: begin
        if (w_match) begin
          w_next    = S_IDLE;
          w_cnt_nxt = '0;
        end else if (r_cnt == '0) begin
          w_next = S_ARMED;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_next    = S_IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_o   <= 2'b00;
      r_delay     <= 1'b0;
      r_ok        <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_state_o   <= enc_state(w_next);
      r_delay     <= (w_next == S_EXIT) || (w_next == S_ENTRY);
      r_ok        <= w_match;
      r_err_pulse <= w_wrong;
    end
  end

  assign bus.state    = r_state_o;
  assign bus.delay    = r_delay;
  assign bus.code_ok  = r_ok;
  assign bus.code_err = r_err_pulse;

endmodule

// File: tb/tb_alarm_fsm.sv
// Self-checking bench for alarm_fsm: code pulses go through a scoreboard queue,
// state/delay timing is checked inline by each scenario task.
module tb_alarm_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  logic [1:0] sb_q[$];

  alarm_fsm_if bus();

  alarm_fsm #(
    .CODE(16'h1234), .EXIT_CYCLES(20), .ENTRY_CYCLES(10), .ALARM_CYCLES(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // want: 0 = no pulse expected, 1 = code_ok, 2 = code_err
  task automatic send_keys(input logic [19:0] seq, input int n, input int want);
    logic [1:0] exp_pulse;
    int waited;
    if (want != 0) sb_q.push_back((want == 1) ? 2'b10 : 2'b01);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.key_valid = 1'b1;
      bus.key_digit = seq[(n-1-i)*4 +: 4];
    end
    @(negedge clk);
    bus.key_valid = 1'b0;
    if (want == 0) begin
      n_total++;
      if ({bus.code_ok, bus.code_err} !== 2'b00)
        $display("FAIL no_pulse: got %b expected 00", {bus.code_ok, bus.code_err});
      else n_pass++;
    end else begin
      waited = 0;
      while (!(bus.code_ok || bus.code_err) && waited < 4) begin
        @(negedge clk);
        waited++;
      end
      exp_pulse = sb_q.pop_front();
      n_total++;
      if ({bus.code_ok, bus.code_err} !== exp_pulse || waited != 0)
        $display("FAIL code_pulse: got %b after %0d cycles expected %b after 0",
                 {bus.code_ok, bus.code_err}, waited, exp_pulse);
      else n_pass++;
    end
  endtask

  task automatic do_arm();
    int w;
    send_keys(20'h01234, 4, 1);
    w = 0;
    while (bus.delay && w < 60) begin
      @(negedge clk);
      w++;
    end
    n_total++;
    if (bus.state !== 2'b01 || bus.delay !== 1'b0)
      $display("FAIL arm_done: got state=%b delay=%b expected 01/0", bus.state, bus.delay);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_digit = 4'h0;
    bus.sensor = 4'h0;
    repeat (3) @(negedge clk);
    n_total++;
    if (bus.state !== 2'b00) $display("FAIL reset_state: got %b expected 00", bus.state);
    else n_pass++;
    n_total++;
    if ({bus.delay, bus.code_ok, bus.code_err} !== 3'b000)
      $display("FAIL reset_outputs: got %b expected 000", {bus.delay, bus.code_ok, bus.code_err});
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_arm_exit();
    int cnt;
    send_keys(20'h01234, 4, 1);
    n_total++;
    if (bus.state !== 2'b01) $display("FAIL exit_state: got %b expected 01", bus.state);
    else n_pass++;
    cnt = 0;
    while (bus.delay && cnt < 100) begin
      cnt++;
      if (cnt == 2) begin
        n_total++;
        if (bus.code_ok !== 1'b0) $display("FAIL ok_width: got %b expected 0", bus.code_ok);
        else n_pass++;
      end
      @(negedge clk);
    end
    n_total++;
    if (cnt != 20) $display("FAIL exit_len: got %0d expected 20", cnt);
    else n_pass++;
    n_total++;
    if (bus.state !== 2'b01) $display("FAIL armed_state: got %b expected 01", bus.state);
    else n_pass++;
    send_keys(20'h01234, 4, 1);
    n_total++;
    if (bus.state !== 2'b00) $display("FAIL disarm: got %b expected 00", bus.state);
    else n_pass++;
  endtask

  task automatic test_ignored_digits();
    send_keys(20'h12A34, 5, 1);
    n_total++;
    if (bus.state !== 2'b01 || bus.delay !== 1'b1)
      $display("FAIL ignored_digit: got state=%b delay=%b expected 01/1", bus.state, bus.delay);
    else n_pass++;
    send_keys(20'h01234, 4, 1);
    n_total++;
    if (bus.state !== 2'b00 || bus.delay !== 1'b0)
      $display("FAIL disarm_exit: got state=%b delay=%b expected 00/0", bus.state, bus.delay);
    else n_pass++;
  endtask

  task automatic test_idle_errors();
    for (int k = 0; k < 3; k++) send_keys(20'h09999, 4, 2);
    n_total++;
    if (bus.state !== 2'b00) $display("FAIL idle_err_state: got %b expected 00", bus.state);
    else n_pass++;
    do_arm();
    send_keys(20'h09999, 4, 2);
    n_total++;
    if (bus.state !== 2'b01) $display("FAIL err_count_cleared: got %b expected 01", bus.state);
    else n_pass++;
    send_keys(20'h01234, 4, 1);
  endtask

  task automatic test_instant();
    int w;
    int cnt;
    do_arm();
    @(negedge clk);
    bus.sensor = 4'b0100;
    w = 0;
    while (bus.state !== 2'b10 && w < 6) begin
      @(negedge clk);
      w++;
    end
    n_total++;
    if (bus.state !== 2'b10 || w > 3)
      $display("FAIL instant_trip: got state=%b after %0d expected 10 within 3", bus.state, w);
    else n_pass++;
    cnt = 0;
    while (bus.state === 2'b10 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    n_total++;
    if (cnt != 50) $display("FAIL alarm_len: got %0d expected 50", cnt);
    else n_pass++;
    n_total++;
    if (bus.state !== 2'b01) $display("FAIL rearm: got %b expected 01", bus.state);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.state !== 2'b10) $display("FAIL retrigger: got %b expected 10", bus.state);
    else n_pass++;
    bus.sensor = 4'b0000;
    send_keys(20'h01234, 4, 1);
    n_total++;
    if (bus.state !== 2'b00) $display("FAIL alarm_disarm: got %b expected 00", bus.state);
    else n_pass++;
  endtask

  task automatic test_entry();
    int w;
    int cnt;
    for (int pass = 0; pass < 2; pass++) begin
      do_arm();
      @(negedge clk);
      bus.sensor = 4'b0001;
      @(negedge clk);
      bus.sensor = 4'b0000;
      w = 0;
      while (!bus.delay && w < 6) begin
        @(negedge clk);
        w++;
      end
      if (pass == 0) begin
        cnt = 0;
        while (bus.delay && cnt < 100) begin
          cnt++;
          @(negedge clk);
        end
        n_total++;
        if (cnt != 10) $display("FAIL entry_len: got %0d expected 10", cnt);
        else n_pass++;
        n_total++;
        if (bus.state !== 2'b10) $display("FAIL entry_timeout: got %b expected 10", bus.state);
        else n_pass++;
        send_keys(20'h01234, 4, 1);
      end else begin
        send_keys(20'h01234, 4, 1);
        n_total++;
        if (bus.state !== 2'b00 || bus.delay !== 1'b0)
          $display("FAIL entry_disarm: got state=%b delay=%b expected 00/0", bus.state, bus.delay);
        else n_pass++;
        repeat (15) @(negedge clk);
        n_total++;
        if (bus.state !== 2'b00) $display("FAIL entry_no_alarm: got %b expected 00", bus.state);
        else n_pass++;
      end
    end
  endtask

  task automatic test_err_alarm();
    do_arm();
    for (int k = 0; k < 3; k++) begin
      send_keys(20'h09999, 4, 2);
      n_total++;
      if (bus.state !== ((k == 2) ? 2'b10 : 2'b01))
        $display("FAIL err_trip_%0d: got %b expected %b", k, bus.state, (k == 2) ? 2'b10 : 2'b01);
      else n_pass++;
    end
    send_keys(20'h0123F, 4, 0);
    send_keys(20'h01234, 4, 1);
    n_total++;
    if (bus.state !== 2'b00) $display("FAIL clear_then_code: got %b expected 00", bus.state);
    else n_pass++;
  endtask

  task automatic test_same_edge();
    logic [1:0] exp_pulse;
    do_arm();
    sb_q.push_back(2'b10);
    @(negedge clk); bus.key_valid = 1'b1; bus.key_digit = 4'h1;
    @(negedge clk); bus.key_digit = 4'h2; bus.sensor = 4'b0010;
    @(negedge clk); bus.key_digit = 4'h3;
    @(negedge clk); bus.key_digit = 4'h4;
    @(negedge clk); bus.key_valid = 1'b0;
    exp_pulse = sb_q.pop_front();
    n_total++;
    if ({bus.code_ok, bus.code_err} !== exp_pulse)
      $display("FAIL same_edge_pulse: got %b expected %b", {bus.code_ok, bus.code_err}, exp_pulse);
    else n_pass++;
    n_total++;
    if (bus.state !== 2'b00) $display("FAIL same_edge_state: got %b expected 00", bus.state);
    else n_pass++;
    bus.sensor = 4'b0000;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int w;
    do_arm();
    bus.sensor = 4'b1000;
    w = 0;
    while (bus.state !== 2'b10 && w < 6) begin
      @(negedge clk);
      w++;
    end
    rst = 1'b1;
    bus.sensor = 4'b0000;
    @(negedge clk);
    n_total++;
    if (bus.state !== 2'b00 || bus.delay !== 1'b0)
      $display("FAIL reset_alarm: got state=%b delay=%b expected 00/0", bus.state, bus.delay);
    else n_pass++;
    rst = 1'b0;
    send_keys(20'h01234, 4, 1);
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.state !== 2'b00 || bus.delay !== 1'b0)
      $display("FAIL reset_exit: got state=%b delay=%b expected 00/0", bus.state, bus.delay);
    else n_pass++;
    rst = 1'b0;
    send_keys(20'h00012, 2, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_keys(20'h00034, 2, 0);
    n_total++;
    if (bus.state !== 2'b00) $display("FAIL reset_buffer: got %b expected 00", bus.state);
    else n_pass++;
    send_keys(20'h0000F, 1, 0);
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.key_digit = 4'h0;
    bus.sensor = 4'h0;
    test_reset();
    test_arm_exit();
    test_ignored_digits();
    test_idle_errors();
    test_instant();
    test_entry();
    test_err_alarm();
    test_same_edge();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
